// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC control, execute redirect, memory read port and decode handoff.
// master = the fetch unit itself, slave = the surrounding core/memory/testbench side.
interface fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 18
);
  logic               fetch_en;
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_next;
  logic               pc_jump;
  logic [ADDR_W-1:0]  jump_offset;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_offset;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_ready;
  logic               fetch_err;

  modport master (
    input  fetch_en, pc_addr, branch_taken, branch_offset, mem_ack, mem_rdata, instr_ready,
    output pc_next, pc_jump, jump_offset, mem_req, mem_addr, instr_valid, instr, instr_addr,
           fetch_err
  );

  modport slave (
    output fetch_en, pc_addr, branch_taken, branch_offset, mem_ack, mem_rdata, instr_ready,
    input  pc_next, pc_jump, jump_offset, mem_req, mem_addr, instr_valid, instr, instr_addr,
           fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: latches PC, reads memory, hands the word to decode, drives PC next/jump.
// Latency: mem_req 2 cycles after fetch_en in IDLE; instr_valid and pc_next the cycle after mem_ack.
// Backpressure: holds the instruction until instr_ready; optional memory timeout under FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_W         = 10,
  parameter int INSTR_W        = 18,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    FETCH    = 3'd2,
    HOLD     = 3'd3,
    REDIRECT = 3'd4,
    DISCARD  = 3'd5
  } state_t;

  state_t              state_q;
  state_t              resume_d;
  logic                mem_req_q;
  logic                pc_next_q;
  logic                pc_jump_q;
  logic                instr_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   jump_offset_q;
  logic [ADDR_W-1:0]   instr_addr_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  // After a completed or abandoned access: fetch again only while fetch_en permits it.
  always_comb resume_d = bus.fetch_en ? ADDR : IDLE;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             fetch_err_q;

  // Expires on the last permitted waiting cycle, so mem_req is high for exactly TIMEOUT_CYCLES.
  assign timeout_hit = ((state_q == FETCH) || (state_q == DISCARD)) && !bus.mem_ack &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting on memory; FETCH continuing into DISCARD is one wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           wait_cnt_q <= '0;
    else if ((state_q == FETCH) || (state_q == DISCARD)) wait_cnt_q <= wait_cnt_q + 1'b1;
    else                                               wait_cnt_q <= '0;
  end

  // Sticky memory-timeout flag; nothing but rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fetch_err_q <= 1'b0;
    else if (timeout_hit) fetch_err_q <= 1'b1;
  end

  assign bus.fetch_err = fetch_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  // Main sequencer: state and all registered outputs. A redirect always shows as pc_jump
  // on the following cycle, whatever the state, which keeps the PC bookkeeping simple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      pc_next_q     <= 1'b0;
      pc_jump_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      mem_addr_q    <= '0;
      jump_offset_q <= '0;
      instr_addr_q  <= '0;
      instr_q       <= '0;
    end else begin
      pc_next_q <= 1'b0;
      pc_jump_q <= bus.branch_taken;
      if (bus.branch_taken) jump_offset_q <= bus.branch_offset;

      case (state_q)
        IDLE: begin
          if (bus.branch_taken)  state_q <= REDIRECT;
          else if (bus.fetch_en) state_q <= ADDR;
        end

        // One settling cycle so any PC update has landed before the address is latched.
        ADDR: begin
          if (bus.branch_taken) begin
            state_q <= REDIRECT;
          end else begin
            mem_addr_q <= bus.pc_addr;
            mem_req_q  <= 1'b1;
            state_q    <= FETCH;
          end
        end

        FETCH: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (bus.branch_taken) begin
              state_q <= REDIRECT;
            end else begin
              instr_q       <= bus.mem_rdata;
              instr_addr_q  <= mem_addr_q;
              instr_valid_q <= 1'b1;
              pc_next_q     <= 1'b1;
              state_q       <= HOLD;
            end
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (bus.branch_taken) begin
            state_q <= DISCARD;
          end
        end

        // A redirect beats a same-cycle instr_ready: the held word is on the wrong path.
        HOLD: begin
          if (bus.branch_taken) begin
            instr_valid_q <= 1'b0;
            state_q       <= REDIRECT;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= resume_d;
          end
        end

        // pc_jump is high here; a fresh redirect keeps us here for another jump.
        REDIRECT: begin
          if (!bus.branch_taken) state_q <= resume_d;
        end

        // The outstanding read must complete before the bus is reused; its data is dropped.
        DISCARD: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= bus.branch_taken ? REDIRECT : resume_d;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.pc_jump     = pc_jump_q;
  assign bus.jump_offset = jump_offset_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = instr_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the PC, memory contents and request lifetimes.
module tb_fetch_unit;
  localparam int AW = 10;
  localparam int IW = 18;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYCLES(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [IW-1:0] mem [1024];
  logic [AW-1:0] pc_model;
  bit            dropped;
  int            n_next, n_jump, n_vld_cyc, n_rise;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: snapshot pre-edge, advance, then check the edge against the model.
  task automatic step();
    logic          p_rst, p_req, p_ack, p_br, p_rdy, p_vld, p_next, p_jump;
    logic [AW-1:0] p_maddr, p_boff, p_joff;
    logic [IW-1:0] p_instr;
    bit            exp_next;
    p_rst = rst;            p_req = bus.mem_req;      p_ack = bus.mem_ack;
    p_br = bus.branch_taken; p_rdy = bus.instr_ready; p_vld = bus.instr_valid;
    p_next = bus.pc_next;   p_jump = bus.pc_jump;     p_maddr = bus.mem_addr;
    p_boff = bus.branch_offset; p_joff = bus.jump_offset; p_instr = bus.instr;
    @(posedge clk);
    #1;
    if (p_rst || rst) begin
      dropped = 1'b0;
      pc_model = '0;
      bus.pc_addr = '0;
      return;
    end
    if (bus.pc_next) n_next++;
    if (bus.pc_jump) n_jump++;
    if (bus.instr_valid) n_vld_cyc++;
    if (bus.instr_valid && !p_vld) n_rise++;

    // A read yields an instruction only if it completes with no redirect seen during its life.
    exp_next = p_req && p_ack && !p_br && !dropped;
    if (p_req && p_ack) dropped = 1'b0;
    else if (p_req && p_br) dropped = 1'b1;

    chk("pc_jump_follows_branch", 32'(bus.pc_jump), 32'(p_br));
    if (p_br) chk("jump_offset", 32'(bus.jump_offset), 32'(p_boff));
    chk("pc_next", 32'(bus.pc_next), 32'(exp_next));
    if (bus.pc_next && bus.pc_jump) chk("next_jump_exclusive", 32'd1, 32'd0);
    if (exp_next) begin
      chk("instr_data", 32'(bus.instr), 32'(mem[p_maddr]));
      chk("instr_addr", 32'(bus.instr_addr), 32'(p_maddr));
    end
    if (p_vld && !p_rdy && !p_br) begin
      chk("instr_valid_hold", 32'(bus.instr_valid), 32'd1);
      chk("instr_stable", 32'(bus.instr), 32'(p_instr));
    end else begin
      chk("instr_valid", 32'(bus.instr_valid), 32'(exp_next));
    end
    if (p_req && !p_ack && !bus.fetch_err) begin
      chk("mem_req_hold", 32'(bus.mem_req), 32'd1);
      chk("mem_addr_hold", 32'(bus.mem_addr), 32'(p_maddr));
    end
    if (p_req && p_ack) chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
    if (bus.instr_valid) chk("no_req_in_hold", 32'(bus.mem_req), 32'd0);

    // The bench plays the PC register.
    if (p_next) pc_model = pc_model + 1'b1;
    if (p_jump) pc_model = pc_model + p_joff;
    bus.pc_addr = pc_model;
    if (bus.mem_req && !p_req) begin
      chk("fetch_addr_is_pc", 32'(bus.mem_addr), 32'(pc_model));
      dropped = 1'b0;
    end
  endtask

  task automatic drive_ack(input logic a);
    bus.mem_ack   = a;
    bus.mem_rdata = a ? mem[bus.mem_addr] : IW'($urandom);
  endtask

  initial begin
    int n0, j0, v0, hi, lat, n_deliv, nr0, ne0;
    for (int i = 0; i < 1024; i++) mem[i] = IW'($urandom);
    mem[0] = 18'h2A5A5;
    rst = 1'b1;
    bus.fetch_en = 1'b0; bus.pc_addr = '0; bus.branch_taken = 1'b0; bus.branch_offset = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    pc_model = '0; dropped = 1'b0;
    n_next = 0; n_jump = 0; n_vld_cyc = 0; n_rise = 0;
    repeat (2) step();

    // Reset state
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_pc_next", 32'(bus.pc_next), 32'd0);
    chk("rst_pc_jump", 32'(bus.pc_jump), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_fetch_err", 32'(bus.fetch_err), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_jump_offset", 32'(bus.jump_offset), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_instr_addr", 32'(bus.instr_addr), 32'd0);
    rst = 1'b0;

    // First fetch from address 0
    bus.fetch_en = 1'b1;
    step();
    chk("addr_state_no_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", 32'(bus.mem_addr), 32'd0);
    drive_ack(1'b1);
    step();
    drive_ack(1'b0);
    chk("first_valid", 32'(bus.instr_valid), 32'd1);
    chk("first_instr", 32'(bus.instr), 32'h2A5A5);
    chk("first_pc_next", 32'(bus.pc_next), 32'd1);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_no_req", 32'(bus.mem_req), 32'd0);
    end
    chk("stall_one_pc_next", 32'(n_next), 32'd1);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("ready_drops_valid", 32'(bus.instr_valid), 32'd0);
    step();
    chk("second_req", 32'(bus.mem_req), 32'd1);
    chk("second_addr", 32'(bus.mem_addr), 32'd1);

    // Redirect during FETCH, memory answers 3 cycles after the branch
    n0 = n_next; j0 = n_jump; v0 = n_vld_cyc;
    bus.branch_taken = 1'b1; bus.branch_offset = 10'd7;
    step();
    bus.branch_taken = 1'b0;
    chk("fetch_branch_jump", 32'(bus.pc_jump), 32'd1);
    chk("fetch_branch_off", 32'(bus.jump_offset), 32'd7);
    step();
    step();
    drive_ack(1'b1);
    step();
    drive_ack(1'b0);
    step();
    chk("discard_one_jump", 32'(n_jump - j0), 32'd1);
    chk("discard_no_next", 32'(n_next - n0), 32'd0);
    chk("discard_no_valid", 32'(n_vld_cyc - v0), 32'd0);
    chk("refetch_req", 32'(bus.mem_req), 32'd1);
    chk("refetch_addr", 32'(bus.mem_addr), 32'd8);

    // Redirect and instr_ready in the same HOLD cycle
    drive_ack(1'b1);
    step();
    drive_ack(1'b0);
    chk("hold_valid", 32'(bus.instr_valid), 32'd1);
    bus.branch_taken = 1'b1; bus.branch_offset = 10'd3; bus.instr_ready = 1'b1;
    step();
    bus.branch_taken = 1'b0; bus.instr_ready = 1'b0;
    chk("hold_branch_drop", 32'(bus.instr_valid), 32'd0);
    chk("hold_branch_jump", 32'(bus.pc_jump), 32'd1);
    step();
    chk("redirect_to_addr", 32'(bus.mem_req), 32'd0);
    chk("jump_one_cycle", 32'(bus.pc_jump), 32'd0);
    step();
    chk("after_redirect_req", 32'(bus.mem_req), 32'd1);
    chk("after_redirect_addr", 32'(bus.mem_addr), 32'd12);

    // Memory never answers
    bus.fetch_en = 1'b0;
    hi = 1;
    for (int i = 0; i < 120; i++) begin
      step();
      if (bus.mem_req) hi++;
    end
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_req_cycles", 32'(hi), 32'd15);
    chk("timeout_err_sticky", 32'(bus.fetch_err), 32'd1);
`else
    chk("no_timeout_req_cycles", 32'(hi), 32'd121);
    chk("no_timeout_err", 32'(bus.fetch_err), 32'd0);
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_clears_err", 32'(bus.fetch_err), 32'd0);
    step();
    rst = 1'b0;

    // Reset in the middle of a fetch, then a stale ack
    bus.fetch_en = 1'b1;
    step();
    step();
    chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_valid", 32'(bus.instr_valid), 32'd0);
    step();
    rst = 1'b0;
    bus.fetch_en = 1'b0;
    drive_ack(1'b1);
    step();
    drive_ack(1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_ack_no_valid", 32'(bus.instr_valid), 32'd0);
      chk("stale_ack_no_req", 32'(bus.mem_req), 32'd0);
    end

    // Random traffic; memory latency kept well inside the timeout
    lat = 0; n_deliv = 0; nr0 = n_rise; ne0 = n_next;
    for (int c = 0; c < 3000; c++) begin
      bus.fetch_en      = ($urandom_range(0, 7) != 0);
      bus.instr_ready   = ($urandom_range(0, 1) == 1);
      bus.branch_taken  = ($urandom_range(0, 11) == 0);
      bus.branch_offset = AW'($urandom);
      if (bus.mem_req) begin
        lat++;
        drive_ack((lat >= 5) || ($urandom_range(0, 2) == 0));
      end else begin
        lat = 0;
        drive_ack(1'b0);
      end
      if (bus.instr_valid && bus.instr_ready && !bus.branch_taken) n_deliv++;
      step();
    end
    chk("random_deliveries", 32'(n_deliv > 100), 32'd1);
    chk("random_next_per_instr", 32'(n_next - ne0), 32'(n_rise - nr0));
    chk("random_no_err", 32'(bus.fetch_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 18, instruction word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum FETCH/DISCARD cycles without mem_ack.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fetch_en  input  1  permits new fetches.
REQ-007 SHALL have port pc_addr  input  ADDR_W  current program counter value.
REQ-008 SHALL have port pc_next  output  1  one-cycle strobe; drives both the PC enable and the PC next inputs.
REQ-009 SHALL have port pc_jump  output  1  one-cycle strobe; drives the PC relative-jump input.
REQ-010 SHALL have port jump_offset  output  ADDR_W  offset presented with pc_jump.
REQ-011 SHALL have port branch_taken  input  1  execute-stage redirect strobe.
REQ-012 SHALL have port branch_offset  input  ADDR_W  redirect offset, valid with branch_taken.
REQ-013 SHALL have port mem_req, mem_addr  output  1, ADDR_W  memory read request and registered address.
REQ-014 SHALL have port mem_ack, mem_rdata  input  1, INSTR_W  read completion and read data.
REQ-015 SHALL have port instr_valid, instr, instr_addr  output  1, INSTR_W, ADDR_W  fetched instruction to decode.
REQ-016 SHALL have port instr_ready  input  1  decode accepts instr.
REQ-017 SHALL have port fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-018 SHALL implement states IDLE, ADDR, FETCH, HOLD, REDIRECT, DISCARD; all outputs registered.
REQ-019 IDLE: on fetch_en, go to ADDR.
REQ-020 ADDR: lasts exactly one cycle; latch pc_addr into mem_addr at exit; go to FETCH.
REQ-021 FETCH: assert mem_req; hold mem_req and mem_addr stable until mem_ack.
REQ-022 FETCH with mem_ack: capture mem_rdata into instr and mem_addr into instr_addr, then go to HOLD; assert pc_next for exactly the first HOLD cycle.
REQ-023 Latency: instr_valid SHALL rise on the cycle after mem_ack and SHALL stay high while in HOLD.
REQ-024 HOLD with instr_ready: drop instr_valid next cycle; go to ADDR if fetch_en is high, otherwise go to IDLE.
REQ-025 branch_taken in IDLE, ADDR or HOLD: register branch_offset into jump_offset; go to REDIRECT; any held instruction is dropped, and a same-cycle instr_ready is ignored.
REQ-026 REDIRECT: assert pc_jump for exactly one cycle; next go to ADDR if fetch_en is high, else IDLE.
REQ-027 branch_taken in FETCH, including a same-cycle mem_ack: register the offset and assert pc_jump next cycle.
REQ-028 Continuing REQ-027: no pc_next SHALL be issued; the branch is handled as follows.
- Same-cycle mem_ack: discard the data and go to REDIRECT-equivalent completion (ADDR/IDLE per fetch_en).
- Otherwise: go to DISCARD.
REQ-029 DISCARD: hold mem_req until mem_ack; drop the data; go to ADDR or IDLE per fetch_en.
REQ-030 A branch_taken received while pc_jump is already pending or in DISCARD SHALL replace jump_offset and re-issue pc_jump.
REQ-031 pc_next and pc_jump SHALL never be high in the same cycle; pc_next SHALL never be issued for a discarded fetch.
REQ-032 fetch_en low SHALL NOT abort an outstanding request; it blocks only new ADDR entries.
REQ-033 mem_addr SHALL update only when leaving ADDR, so that PC updates are always settled before the latch.

Reset
REQ-034 On rst: state is IDLE; mem_req, pc_next, pc_jump, instr_valid and fetch_err are 0; mem_addr, jump_offset, instr and instr_addr are 0.
REQ-035 Reset during FETCH or DISCARD SHALL drop mem_req immediately; any later mem_ack in IDLE SHALL be ignored.

Configuration
REQ-036 Macro FETCH_TIMEOUT_EN defined: count cycles spent in FETCH/DISCARD.
- When the count reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, set fetch_err, go to IDLE.
- fetch_err SHALL be cleared only by rst.
REQ-037 Macro FETCH_TIMEOUT_EN undefined: no counter; fetch_err is tied 0; the unit waits indefinitely for mem_ack.

Verification
REQ-038 Reset, pc_addr=0, fetch_en=1, 1-cycle mem_ack with rdata=18'h2A5A5 -> mem_addr=0; instr=18'h2A5A5 and instr_valid the cycle after ack; one pc_next pulse.
REQ-039 instr_ready held 0 for 5 cycles -> instr_valid stays 1, no mem_req, exactly one pc_next; after ready, next fetch uses pc_addr=1.
REQ-040 branch_taken with offset 10'd7 during FETCH, mem_ack 3 cycles later -> single pc_jump with jump_offset=7; data dropped, no pc_next, no instr_valid; refetch after ack at the updated pc_addr.
REQ-041 branch_taken and instr_ready in the same HOLD cycle -> instr dropped, pc_jump 1 cycle later, then ADDR.
REQ-042 FETCH_TIMEOUT_EN defined, mem_ack never asserted -> mem_req drops after 15 cycles, fetch_err=1 until rst; undefined -> mem_req held 100+ cycles.
REQ-043 rst asserted mid-FETCH -> mem_req and instr_valid are 0 immediately; a stale mem_ack afterward produces no instr_valid.
